textmode_fb_sequencer: RTL and testbench

- Command sequencer and framebuffer-port arbiter for the text-mode GPU.
- Takes a byte stream of characters and control codes, interprets it (cursor moves, clear, scroll), and issues all character-buffer writes through one single-port RAM.
- Shares that RAM port with the pixel scan-out reader; scan-out has strict priority.
- Replaces a direct-write buffer with a single-port RAM and adds hardware scrolling.

---
 rtl/textmode_pkg.sv | 29 ++
 rtl/fb_port_arbiter.sv | 39 +++
 rtl/textmode_fb_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_textmode_fb_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/textmode_pkg.sv
// Shared definitions for the text-mode framebuffer sequencer.
// Screen geometry defaults, control codes and the sequencer state set.
package textmode_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 60;
    localparam int AW_DEF   = 13;

    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] CLR = 8'h7F;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        CLEAR,
        SCROLL_RD,
        SCROLL_CAP,
        SCROLL_WR,
        SCROLL_BLANK
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/fb_port_arbiter.sv
// Single RAM port shared between scan-out and the command sequencer.
// Scan-out always wins; a blocked sequencer access simply retries.
module fb_port_arbiter #(
    parameter int AW = 13,
    parameter int DW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_scan_req,
    input  logic [AW-1:0] i_scan_addr,
    input  logic          i_seq_req,
    input  logic          i_seq_we,
    input  logic [AW-1:0] i_seq_addr,
    input  logic [DW-1:0] i_seq_wdata,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [DW-1:0] o_ram_wdata,
    output logic          o_seq_grant,
    output logic          o_scan_valid
);

    logic r_scan_valid;

    assign o_seq_grant  = i_seq_req & ~i_scan_req;
    assign o_ram_addr   = i_scan_req ? i_scan_addr : i_seq_addr;
    assign o_ram_we     = i_seq_we & o_seq_grant;
    assign o_ram_wdata  = i_seq_wdata;
    assign o_scan_valid = r_scan_valid;

    // Scan read data appears one cycle after the request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_valid <= 1'b0;
        end else begin
            r_scan_valid <= i_scan_req;
        end
    end

endmodule

// File: rtl/textmode_fb_sequencer.sv
// Text-mode command sequencer: interprets a byte stream and issues
// character writes, clears and scrolls through a shared RAM port.
module textmode_fb_sequencer
    import textmode_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          CLK_SYS,
    input  logic          RST,
    input  logic          CMD_VALID,
    input  logic [7:0]    CMD_DATA,
    output logic          CMD_READY,
    input  logic          SCAN_REQ,
    input  logic [AW-1:0] SCAN_ADDR,
    output logic [6:0]    SCAN_DATA,
    output logic          SCAN_VALID,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_WE,
    output logic [6:0]    RAM_WDATA,
    input  logic [6:0]    RAM_RDATA,
    output logic [6:0]    CURSOR_X,
    output logic [5:0]    CURSOR_Y,
    output logic          BUSY
);

    localparam logic [AW-1:0] A_COLS  = AW'(COLS);
    localparam logic [AW-1:0] A_LAST  = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] A_BLANK = AW'((ROWS - 1) * COLS);
    localparam logic [6:0]    X_LAST  = 7'(COLS - 1);
    localparam logic [5:0]    Y_LAST  = 6'(ROWS - 1);

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [6:0]      r_cur_x;
    logic [5:0]      r_cur_y;
    logic [AW-1:0]   r_idx;
    logic [6:0]      r_hold;

    logic            w_seq_req;
    logic            w_seq_we;
    logic [AW-1:0]   w_seq_addr;
    logic [6:0]      w_seq_wdata;
    logic            w_grant;
    logic [AW-1:0]   w_cur_addr;

    assign w_cur_addr = AW'(r_cur_y) * A_COLS + AW'(r_cur_x);

    assign CMD_READY = (r_state == IDLE);
    assign BUSY      = (r_state != IDLE);
    assign CURSOR_X  = r_cur_x;
    assign CURSOR_Y  = r_cur_y;
    assign SCAN_DATA = RAM_RDATA;

    // RAM access the current state wants to make, before arbitration.
    always_comb begin
        w_seq_req   = 1'b0;
        w_seq_we    = 1'b0;
        w_seq_addr  = '0;
        w_seq_wdata = '0;
        unique case (r_state)
            WRITE: begin
                w_seq_req   = 1'b1;
                w_seq_we    = 1'b1;
                w_seq_addr  = w_cur_addr;
                w_seq_wdata = r_cmd[6:0];
            end
            CLEAR: begin
                w_seq_req  = 1'b1;
                w_seq_we   = 1'b1;
                w_seq_addr = r_idx;
            end
            SCROLL_RD: begin
                w_seq_req  = 1'b1;
                w_seq_addr = r_idx;
            end
            SCROLL_WR: begin
                w_seq_req   = 1'b1;
                w_seq_we    = 1'b1;
                w_seq_addr  = r_idx - A_COLS;
                w_seq_wdata = r_hold;
            end
            SCROLL_BLANK: begin
                w_seq_req  = 1'b1;
                w_seq_we   = 1'b1;
                w_seq_addr = r_idx;
            end
            default: begin
            end
        endcase
    end

    fb_port_arbiter #(
        .AW (AW),
        .DW (7)
    ) u_arb (
        .i_clk        (CLK_SYS),
        .i_rst_n      (RST),
        .i_scan_req   (SCAN_REQ),
        .i_scan_addr  (SCAN_ADDR),
        .i_seq_req    (w_seq_req),
        .i_seq_we     (w_seq_we),
        .i_seq_addr   (w_seq_addr),
        .i_seq_wdata  (w_seq_wdata),
        .o_ram_addr   (RAM_ADDR),
        .o_ram_we     (RAM_WE),
        .o_ram_wdata  (RAM_WDATA),
        .o_seq_grant  (w_grant),
        .o_scan_valid (SCAN_VALID)
    );

    // Command FSM: decode, cursor update, clear and scroll loops.
    always_ff @(posedge CLK_SYS or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (CMD_VALID) begin
                        r_cmd   <= CMD_DATA;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_state <= IDLE;
                    unique case (1'b1)
                        (r_cmd == LF): begin
                            if (r_cur_y == Y_LAST) begin
                                r_idx   <= A_COLS;
                                r_state <= SCROLL_RD;
                            end else begin
                                r_cur_y <= r_cur_y + 6'd1;
                            end
                        end
                        (r_cmd == CR): begin
                            r_cur_x <= '0;
                        end
                        (r_cmd == BS): begin
                            if (r_cur_x != '0)
                                r_cur_x <= r_cur_x - 7'd1;
                        end
                        (r_cmd == CLR): begin
                            r_idx   <= '0;
                            r_state <= CLEAR;
                        end
                        is_printable(r_cmd): begin
                            r_state <= WRITE;
                        end
                        default: begin
                        end
                    endcase
                end
                WRITE: begin
                    if (w_grant) begin
                        if (r_cur_x == X_LAST) begin
                            r_cur_x <= '0;
                            if (r_cur_y == Y_LAST) begin
                                r_idx   <= A_COLS;
                                r_state <= SCROLL_RD;
                            end else begin
                                r_cur_y <= r_cur_y + 6'd1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cur_x <= r_cur_x + 7'd1;
                            r_state <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    if (w_grant) begin
                        if (r_idx == A_LAST) begin
                            r_cur_x <= '0;
                            r_cur_y <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                SCROLL_RD: begin
                    if (w_grant)
                        r_state <= SCROLL_CAP;
                end
                SCROLL_CAP: begin
                    r_hold  <= RAM_RDATA;
                    r_state <= SCROLL_WR;
                end
                SCROLL_WR: begin
                    if (w_grant) begin
                        if (r_idx == A_LAST) begin
                            r_idx   <= A_BLANK;
                            r_state <= SCROLL_BLANK;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= SCROLL_RD;
                        end
                    end
                end
                SCROLL_BLANK: begin
                    if (w_grant) begin
                        if (r_idx == A_LAST) begin
                            r_cur_y <= Y_LAST;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_textmode_fb_sequencer.sv
// Self-checking bench for textmode_fb_sequencer.
// Expected RAM writes flow through a scoreboard queue.
module tb_textmode_fb_sequencer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int AW    = 13;
    localparam int N     = COLS * ROWS;
    localparam int BOUND = 40000;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [7:0] cmd;
        int         x;
        int         y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_data = '0;
    logic          cmd_ready;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic [6:0]    scan_data;
    logic          scan_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [6:0]    ram_wdata;
    logic [6:0]    ram_rdata = '0;
    logic [6:0]    cursor_x;
    logic [5:0]    cursor_y;
    logic          busy;
    logic          preload_go = 1'b0;

    logic [6:0]    ram [0:(1<<AW)-1];
    int            ref_mem [0:N-1];
    wr_t           exp_q [$];
    int            tests = 0;
    int            fails = 0;
    int            wr_count = 0;
    int            mx = 0;
    int            my = 0;
    vec_t          tbl [17];

    always #5 clk = ~clk;

    textmode_fb_sequencer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) dut (
        .CLK_SYS    (clk),
        .RST        (rst_n),
        .CMD_VALID  (cmd_valid),
        .CMD_DATA   (cmd_data),
        .CMD_READY  (cmd_ready),
        .SCAN_REQ   (scan_req),
        .SCAN_ADDR  (scan_addr),
        .SCAN_DATA  (scan_data),
        .SCAN_VALID (scan_valid),
        .RAM_ADDR   (ram_addr),
        .RAM_WE     (ram_we),
        .RAM_WDATA  (ram_wdata),
        .RAM_RDATA  (ram_rdata),
        .CURSOR_X   (cursor_x),
        .CURSOR_Y   (cursor_y),
        .BUSY       (busy)
    );

    // Single-port RAM, one-cycle read latency, with a bulk preload.
    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < N; i++) ram[i] <= 7'(i / COLS);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        ref_mem[a] = d;
    endtask

    task automatic model_lf();
        if (my == ROWS - 1) begin
            for (int i = COLS; i < N; i++) push_wr(i - COLS, ref_mem[i]);
            for (int i = (ROWS - 1) * COLS; i < N; i++) push_wr(i, 0);
        end else begin
            my++;
        end
    endtask

    task automatic model_cmd(input logic [7:0] c);
        if (c == 8'h0A) begin
            model_lf();
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) mx--;
        end else if (c == 8'h7F) begin
            for (int i = 0; i < N; i++) push_wr(i, 0);
            mx = 0;
            my = 0;
        end else if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(my * COLS + mx, int'(c[6:0]));
            if (mx == COLS - 1) begin
                mx = 0;
                model_lf();
            end else begin
                mx++;
            end
        end
    endtask

    // Scan read-back, scan/write exclusion and write scoreboard.
    task automatic monitor();
        logic       prev_req = 1'b0;
        logic [6:0] prev_exp = '0;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (prev_req) begin
                    chk("scan_valid", int'(scan_valid), 1);
                    chk("scan_data", int'(scan_data), int'(prev_exp));
                end else if (scan_valid) begin
                    chk("scan_valid_spurious", 1, 0);
                end
                if (scan_req) chk("we_under_scan", int'(ram_we), 0);
                prev_req = scan_req;
                prev_exp = ram[scan_addr];
                if (ram_we) begin
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wr_addr", int'(ram_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        tests++;
                        if (int'(ram_addr) != e.addr ||
                            int'(ram_wdata) != e.data) begin
                            fails++;
                            $display("FAIL wr: got a=%0d d=%0h want a=%0d d=%0h",
                                     ram_addr, ram_wdata, e.addr, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [7:0] c);
        int n = 0;
        while (!cmd_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_wait_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = c;
        model_cmd(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(output int lat, output int blow);
        lat  = 0;
        blow = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!busy && !cmd_ready) blow++;
        end while (!cmd_ready && lat < BOUND);
        if (!cmd_ready) chk("done_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] c, output int lat, output int blow);
        issue(c);
        finish_cmd(lat, blow);
    endtask

    task automatic preload();
        @(posedge clk); #1;
        preload_go = 1'b1;
        @(posedge clk); #1;
        preload_go = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = i / COLS;
    endtask

    task automatic check_scrolled(input string name);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (i < (ROWS - 1) * COLS) begin
                if (int'(ram[i]) != i / COLS + 1) bad++;
            end else if (ram[i] != 7'd0) begin
                bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        chk({name, "_x"}, int'(cursor_x), x);
        chk({name, "_y"}, int'(cursor_y), y);
    endtask

    initial begin
        int lat;
        int blow;
        int w0;
        logic done;

        tbl[0]  = '{8'h0A, 0, 2};
        tbl[1]  = '{8'h0A, 0, 3};
        tbl[2]  = '{8'h43, 1, 3};
        tbl[3]  = '{8'h44, 2, 3};
        tbl[4]  = '{8'h45, 3, 3};
        tbl[5]  = '{8'h46, 4, 3};
        tbl[6]  = '{8'h47, 5, 3};
        tbl[7]  = '{8'h08, 4, 3};
        tbl[8]  = '{8'h0D, 0, 3};
        tbl[9]  = '{8'h0A, 0, 4};
        tbl[10] = '{8'h08, 0, 4};
        tbl[11] = '{8'h00, 0, 4};
        tbl[12] = '{8'h1B, 0, 4};
        tbl[13] = '{8'h80, 0, 4};
        tbl[14] = '{8'hFF, 0, 4};
        tbl[15] = '{8'h7E, 1, 4};
        tbl[16] = '{8'h20, 2, 4};

        for (int i = 0; i < N; i++) ref_mem[i] = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_scan_valid", int'(scan_valid), 0);
        chk("rst_we", int'(ram_we), 0);
        check_cursor("rst_cur", 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        w0 = wr_count;
        send(8'h41, lat, blow);
        chk("a_latency", lat, 3);
        chk("a_wr_count", wr_count - w0, 1);
        check_cursor("a_cur", 1, 0);

        for (int k = 0; k < 78; k++) send(8'h61 + 8'(k % 26), lat, blow);
        check_cursor("row0_end", 79, 0);
        send(8'h42, lat, blow);
        check_cursor("wrap_cur", 0, 1);

        for (int i = 0; i < 17; i++) begin
            send(tbl[i].cmd, lat, blow);
            check_cursor($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y);
        end

        issue(8'h5A);
        for (int k = 0; k < 10; k++) begin
            scan_req  = 1'b1;
            scan_addr = AW'(k * 37 + 5);
            @(posedge clk); #1;
        end
        scan_req = 1'b0;
        @(negedge clk);
        chk("wr_after_release", int'(ram_we), 1);
        finish_cmd(lat, blow);
        check_cursor("contend_cur", 3, 4);
        chk("contend_q_empty", exp_q.size(), 0);

        issue(8'h7F);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_we", int'(ram_we), 0);
        chk("abort_busy", int'(busy), 0);
        check_cursor("abort_cur", 0, 0);
        exp_q.delete();
        w0 = wr_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_wr", wr_count - w0, 0);
        mx = 0;
        my = 0;

        for (int k = 0; k < 10; k++) send(8'h0A, lat, blow);
        for (int k = 0; k < 10; k++) send(8'h30 + 8'(k), lat, blow);
        check_cursor("pre_clr", 10, 10);
        w0 = wr_count;
        send(8'h7F, lat, blow);
        chk("clr_latency", lat, N + 2);
        chk("clr_busy_low", blow, 0);
        chk("clr_wr_count", wr_count - w0, N);
        chk("clr_q_empty", exp_q.size(), 0);
        check_cursor("clr_cur", 0, 0);

        for (int k = 0; k < 59; k++) send(8'h0A, lat, blow);
        for (int k = 0; k < 7; k++) send(8'h2A, lat, blow);
        check_cursor("pre_scroll", 7, 59);
        preload();
        send(8'h0A, lat, blow);
        chk("scroll_latency", lat, 3 * COLS * (ROWS - 1) + COLS + 2);
        chk("scroll_busy_low", blow, 0);
        chk("scroll_q_empty", exp_q.size(), 0);
        check_cursor("scroll_cur", 7, 59);
        check_scrolled("scroll_image");

        preload();
        done = 1'b0;
        fork
            begin
                send(8'h0A, lat, blow);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    scan_req  = ($urandom_range(0, 3) == 0);
                    scan_addr = AW'($urandom_range(0, N - 1));
                end
                scan_req = 1'b0;
            end
        join
        chk("rscroll_q_empty", exp_q.size(), 0);
        check_cursor("rscroll_cur", 7, 59);
        check_scrolled("rscroll_image");

        for (int k = 0; k < 72; k++) send(8'h2E, lat, blow);
        check_cursor("pre_wrap_scroll", 79, 59);
        send(8'h57, lat, blow);
        chk("wscroll_q_empty", exp_q.size(), 0);
        check_cursor("wscroll_cur", 0, 59);
        chk("wscroll_last_row", int'(ram[N - 1]), 0);
        chk("wscroll_moved", int'(ram[N - 1 - COLS]), 8'h57);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
